// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready operand and result bus for the pipelined carry-lookahead adder.
// The adder side uses the slave modport; the producer/consumer side uses master.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             p;
    logic             g;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, p, g
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, p, g
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 16-bit CLA chunk resolved per
// stage, inter-chunk carry registered, whole pipeline stalls as one unit.
module pipelined_cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int NCH = WIDTH / 16;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        p;
        logic        g;
    } chunk_t;

    // 16-bit slice: four 4-bit groups with a lookahead unit across the groups.
    function automatic chunk_t cla16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [15:0] pb, gb, cb;
        logic [3:0]  gp, gg;
        logic [3:0]  gc;
        chunk_t      r;
        pb = x ^ y;
        gb = x & y;
        for (int j = 0; j < 4; j++) begin
            gp[j] = &pb[4*j +: 4];
            gg[j] = gb[4*j+3] | (pb[4*j+3] & gb[4*j+2]) | (pb[4*j+3] & pb[4*j+2] & gb[4*j+1])
                  | (pb[4*j+3] & pb[4*j+2] & pb[4*j+1] & gb[4*j]);
        end
        gc[0] = ci;
        gc[1] = gg[0] | (gp[0] & ci);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & ci);
        r.p = &gp;
        r.g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
        r.c = r.g | (r.p & ci);
        for (int j = 0; j < 4; j++) begin
            cb[4*j] = gc[j];
            for (int i = 1; i < 4; i++)
                cb[4*j+i] = gb[4*j+i-1] | (pb[4*j+i-1] & cb[4*j+i-1]);
        end
        r.s = pb ^ cb;
        return r;
    endfunction

    logic             vld_p  [NCH];
    logic [WIDTH-1:0] a_p    [NCH];
    logic [WIDTH-1:0] b_p    [NCH];
    logic [WIDTH-1:0] s_p    [NCH];
    logic             c_p    [NCH];
    logic             pw_p   [NCH];
    logic             gw_p   [NCH];
    logic             ovf_p;
    logic             zero_p;

    logic             v_in   [NCH];
    logic [WIDTH-1:0] a_in   [NCH];
    logic [WIDTH-1:0] b_in   [NCH];
    logic [WIDTH-1:0] s_in   [NCH];
    logic             c_in   [NCH];
    logic             p_in   [NCH];
    logic             g_in   [NCH];
    chunk_t           ch     [NCH];
    logic [WIDTH-1:0] s_nx   [NCH];
    logic             ovf_nx;
    logic             stall;

    assign stall        = vld_p[NCH-1] && !bus.out_ready;
    assign bus.in_ready = !stall;

    // Stage 0 takes the pre-processed operation; later stages take the previous register.
    always_comb begin
        v_in[0] = bus.in_valid;
        a_in[0] = bus.a;
        b_in[0] = bus.sub ? ~bus.b : bus.b;
        s_in[0] = '0;
        c_in[0] = bus.sub ? ~bus.cin : bus.cin;
        p_in[0] = 1'b1;
        g_in[0] = 1'b0;
        for (int k = 1; k < NCH; k++) begin
            v_in[k] = vld_p[k-1];
            a_in[k] = a_p[k-1];
            b_in[k] = b_p[k-1];
            s_in[k] = s_p[k-1];
            c_in[k] = c_p[k-1];
            p_in[k] = pw_p[k-1];
            g_in[k] = gw_p[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            ch[k]   = cla16(a_in[k][16*k +: 16], b_in[k][16*k +: 16], c_in[k]);
            s_nx[k] = s_in[k];
            s_nx[k][16*k +: 16] = ch[k].s;
        end
        ovf_nx = (a_in[NCH-1][WIDTH-1] == b_in[NCH-1][WIDTH-1])
              && (s_nx[NCH-1][WIDTH-1] != a_in[NCH-1][WIDTH-1]);
    end

    // Stage registers: chunk k result lands in stage k; the last stage is the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
                c_p[k]   <= 1'b0;
                pw_p[k]  <= 1'b0;
                gw_p[k]  <= 1'b0;
            end
            ovf_p  <= 1'b0;
            zero_p <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < NCH; k++) begin
                vld_p[k] <= v_in[k];
                a_p[k]   <= a_in[k];
                b_p[k]   <= b_in[k];
                s_p[k]   <= s_nx[k];
                c_p[k]   <= ch[k].c;
                pw_p[k]  <= ch[k].p & p_in[k];
                gw_p[k]  <= ch[k].g | (ch[k].p & g_in[k]);
            end
            ovf_p  <= ovf_nx;
            zero_p <= ~|s_nx[NCH-1];
        end
    end

    assign bus.out_valid = vld_p[NCH-1];
    assign bus.sum       = s_p[NCH-1];
    assign bus.cout      = c_p[NCH-1];
    assign bus.ovf       = ovf_p;
    assign bus.zero      = zero_p;
    assign bus.p         = pw_p[NCH-1];
    assign bus.g         = gw_p[NCH-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder at WIDTH 16, 32 and 64: directed vector table,
// back-pressure and mid-flight reset sequences, and random streams against an arithmetic model.
module tb_pipelined_cla_adder;
    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        p;
        logic        g;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        p;
        logic        g;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int got16 = 0, got32 = 0, got64 = 0;
    res_t q16[$], q32[$], q64[$];

    pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
    pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();
    pipelined_cla_adder_if #(.WIDTH(64)) bus64 ();

    pipelined_cla_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    pipelined_cla_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    pipelined_cla_adder #(.WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    // Reference: plain wide integer arithmetic on the w-bit operands.
    function automatic res_t model(int w, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
        logic [127:0] mask, aa, bb, full, gen;
        res_t r;
        mask   = (128'd1 << w) - 128'd1;
        aa     = {64'd0, a} & mask;
        bb     = (sub ? ~{64'd0, b} : {64'd0, b}) & mask;
        full   = aa + bb + {127'd0, sub ? ~cin : cin};
        gen    = (aa + bb) >> w;
        r.sum  = full[63:0] & mask[63:0];
        r.cout = full[w];
        r.g    = gen[0];
        r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        r.zero = (r.sum == 64'd0);
        r.p    = ((aa ^ bb) == mask);
        return r;
    endfunction

    function automatic res_t act(logic [63:0] s, logic co, logic ov, logic z, logic pp, logic gg);
        res_t r;
        r.sum = s; r.cout = co; r.ovf = ov; r.zero = z; r.p = pp; r.g = gg;
        return r;
    endfunction

    task automatic cmp_res(string nm, res_t a, res_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got sum=%h c=%b v=%b z=%b p=%b g=%b, expected sum=%h c=%b v=%b z=%b p=%b g=%b",
                     nm, a.sum, a.cout, a.ovf, a.zero, a.p, a.g, e.sum, e.cout, e.ovf, e.zero, e.p, e.g);
        end
    endtask

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, a, e);
        end
    endtask

    // Scoreboards: accept recorded before the edge that takes it, result popped before the edge that consumes it.
    always @(negedge clk) if (rst_n) begin
        if (bus16.out_valid && bus16.out_ready) begin
            if (q16.size() == 0) chk("r16_extra_out_valid", 64'd1, 64'd0);
            else begin
                cmp_res("r16", act({48'd0, bus16.sum}, bus16.cout, bus16.ovf, bus16.zero, bus16.p, bus16.g), q16.pop_front());
                got16++;
            end
        end
        if (bus16.in_valid && bus16.in_ready)
            q16.push_back(model(16, {48'd0, bus16.a}, {48'd0, bus16.b}, bus16.cin, bus16.sub));
    end

    always @(negedge clk) if (rst_n) begin
        if (bus32.out_valid && bus32.out_ready) begin
            if (q32.size() == 0) chk("r32_extra_out_valid", 64'd1, 64'd0);
            else begin
                cmp_res("r32", act({32'd0, bus32.sum}, bus32.cout, bus32.ovf, bus32.zero, bus32.p, bus32.g), q32.pop_front());
                got32++;
            end
        end
        if (bus32.in_valid && bus32.in_ready)
            q32.push_back(model(32, {32'd0, bus32.a}, {32'd0, bus32.b}, bus32.cin, bus32.sub));
    end

    always @(negedge clk) if (rst_n) begin
        if (bus64.out_valid && bus64.out_ready) begin
            if (q64.size() == 0) chk("r64_extra_out_valid", 64'd1, 64'd0);
            else begin
                cmp_res("r64", act(bus64.sum, bus64.cout, bus64.ovf, bus64.zero, bus64.p, bus64.g), q64.pop_front());
                got64++;
            end
        end
        if (bus64.in_valid && bus64.in_ready)
            q64.push_back(model(64, bus64.a, bus64.b, bus64.cin, bus64.sub));
    end

    task automatic drv32(logic v, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        bus32.in_valid = v; bus32.a = a; bus32.b = b; bus32.cin = cin; bus32.sub = sub;
    endtask

    task automatic drv_all(logic v, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
        bus16.in_valid = v; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.cin = cin; bus16.sub = sub;
        drv32(v, a[31:0], b[31:0], cin, sub);
        bus64.in_valid = v; bus64.a = a; bus64.b = b; bus64.cin = cin; bus64.sub = sub;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(5))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_8000_8000;
            3:       return 64'h7FFF_FFFF_7FFF_7FFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        int   lat;
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        drv_all(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        bus16.out_ready = 1'b1; bus32.out_ready = 1'b1; bus64.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'({bus16.out_valid, bus32.out_valid, bus64.out_valid}), 64'd0);
        chk("rst_sum", 64'(bus32.sum), 64'd0);
        chk("rst_flags", 64'({bus32.cout, bus32.ovf, bus32.zero, bus32.p, bus32.g}), 64'd0);
        chk("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drv32(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
            @(posedge clk);
            #1 bus32.in_valid = 1'b0;
            lat = 1;
            while (!bus32.out_valid && lat < 10) begin
                @(posedge clk);
                #1 lat++;
            end
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd2);
            @(negedge clk);
            cmp_res($sformatf("tbl%0d", i),
                    act({32'd0, bus32.sum}, bus32.cout, bus32.ovf, bus32.zero, bus32.p, bus32.g),
                    act({32'd0, tbl[i].sum}, tbl[i].cout, tbl[i].ovf, tbl[i].zero, tbl[i].p, tbl[i].g));
            @(posedge clk);
            #1;
        end

        // Back-pressure: six ops with in_valid held, out_ready low for cycles 3..5.
        begin
            int          sent, cyc, g0;
            logic        need;
            logic [31:0] held;
            sent = 0; cyc = 0; need = 1'b1; held = '0; g0 = got32;
            while ((got32 - g0) < 6 && cyc < 40) begin
                bus32.out_ready = !(cyc >= 3 && cyc < 6);
                if (sent < 6) begin
                    if (need) begin
                        drv32(1'b1, 32'(pick()), 32'(pick()), 1'($urandom_range(1)), 1'($urandom_range(1)));
                        need = 1'b0;
                    end
                end else bus32.in_valid = 1'b0;
                @(negedge clk);
                if (cyc >= 3 && cyc < 6) begin
                    chk($sformatf("bp_in_ready_c%0d", cyc), 64'(bus32.in_ready), 64'd0);
                    chk($sformatf("bp_out_valid_c%0d", cyc), 64'(bus32.out_valid), 64'd1);
                    if (cyc == 3) held = bus32.sum;
                    else chk($sformatf("bp_hold_c%0d", cyc), 64'(bus32.sum), 64'(held));
                end
                if (bus32.in_valid && bus32.in_ready) begin
                    sent++;
                    need = 1'b1;
                end
                @(posedge clk);
                #1 cyc++;
            end
            bus32.in_valid = 1'b0;
            bus32.out_ready = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            chk("bp_result_count", 64'(got32 - g0), 64'd6);
            chk("bp_pending", 64'(q32.size()), 64'd0);
        end

        // Reset with two operations in flight on all widths.
        drv_all(1'b1, pick(), pick(), 1'b0, 1'b0);
        @(posedge clk);
        #1 drv_all(1'b1, pick(), pick(), 1'b1, 1'b1);
        @(posedge clk);
        #1 drv_all(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'({bus16.out_valid, bus32.out_valid, bus64.out_valid}), 64'd0);
        chk("mid_rst_sum32", 64'(bus32.sum), 64'd0);
        chk("mid_rst_sum64", bus64.sum, 64'd0);
        chk("mid_rst_flags", 64'({bus32.cout, bus32.ovf, bus32.zero, bus32.p, bus32.g}), 64'd0);
        q16.delete(); q32.delete(); q64.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 chk($sformatf("post_rst_idle%0d", i),
                   64'({bus16.out_valid, bus32.out_valid, bus64.out_valid}), 64'd0);
        end
        begin
            int h16, h32, h64;
            h16 = got16; h32 = got32; h64 = got64;
            drv_all(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
            @(posedge clk);
            #1 drv_all(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
            repeat (6) @(posedge clk);
            #1;
            chk("post_rst_results", 64'({8'(got16 - h16), 8'(got32 - h32), 8'(got64 - h64)}), 64'h01_01_01);
        end

        // Random streams into all three widths, out_ready held high.
        for (int i = 0; i < 300; i++) begin
            drv_all($urandom_range(3) != 0, pick(), pick(), 1'($urandom_range(1)), 1'($urandom_range(1)));
            @(posedge clk);
            #1;
        end
        drv_all(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("rand_pending", 64'({16'(q16.size()), 16'(q32.size()), 16'(q64.size())}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor. The WIDTH-bit operand is split into 16-bit chunks, and each chunk is a 4-bit-group carry-lookahead slice with a lookahead carry unit. One chunk is resolved per pipeline stage, with the inter-chunk carry registered between stages. Operands enter and results leave through valid/ready handshakes, so the block sits directly in the datapath as a fully pipelined ALU adder that accepts one operation per cycle.

## Interface
- WIDTH, 32: operand width; must be a multiple of 16 and at least 16. NCH = WIDTH/16 is the number of stages.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  an operation is presented on a, b, cin, sub.
- in_ready  output  1  the block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in when sub=0; borrow-in when sub=1.
- sub  input  1  0 = add, 1 = subtract (a - b).
- out_valid  output  1  a result is held on the outputs.
- out_ready  input  1  the downstream stage takes the result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB. For subtraction, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.
- p  output  1  block propagate of the whole word (AND of all chunk propagates).
- g  output  1  block generate of the whole word.

## Operation
- An operation is accepted when in_valid && in_ready.
- Pre-processing at accept time:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
- Stage k (k = 0..NCH-1) adds chunk k, bits [16k+15:16k], of a and b_eff using the incoming carry.
  - Inside each chunk: four 4-bit groups, each computing group P/G.
  - The chunk lookahead unit produces the group carries c1..c4 from cin, P and G:
    - c1 = G0 | P0·cin
    - c2 = G1 | P1·G0 | P1·P0·cin
    - (and so on for c3, c4)
  - The chunk carry-out (c4) is registered into stage k+1.
- Each stage register holds: a valid bit, the full a and b_eff, the sum bits computed so far, the running carry, the running word P/G, and the operand sign bits needed for ovf.
- Word P/G accumulate across stages:
  - P = P_hi & P_lo
  - G = G_hi | P_hi·G_lo
- Flag computation in the last stage:
  - cout = final carry.
  - ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
  - zero = ~|sum.
- The pipeline advances as a single unit:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - When not stalled, every stage loads from the stage before it. Stage 0 loads the new operation, or a bubble (valid = 0) if nothing is accepted.
- While stalled, all stage registers and outputs hold. This includes bubbles; bubbles are not compressed.
- Output registers are the last stage register: sum, cout, ovf, zero, p and g are valid only while out_valid = 1. They are don't-care otherwise, but must still be deterministic.

## Timing
- Reset values (asynchronous assert, synchronous release on the next clk edge):
  - all stage valid bits = 0
  - out_valid = 0
  - sum = 0, cout = 0, ovf = 0, zero = 0, p = 0, g = 0
  - in_ready = 1
- Latency: an operation accepted at edge t has out_valid = 1 after edge t+NCH. Example: NCH = 2 gives a result 2 cycles after accept.
- Throughput: one operation per cycle when out_ready is held high. Back-to-back results appear on consecutive cycles, in order.
- Simultaneous out_ready && in_valid while the pipeline is full: the output is consumed and a new operation is accepted in the same edge. There are no lost or duplicated results.
- Stall: in_ready deasserts in the same cycle that out_valid && !out_ready is true, as combinational logic from registered out_valid and the out_ready input. It reasserts the cycle out_ready rises.
- Reset asserted mid-operation: all in-flight operations are discarded immediately. No result from before the reset ever appears after release.
- WIDTH = 16 (NCH = 1) is legal and gives 1-cycle latency.
- Critical path per stage: one 16-bit chunk. No ripple carry crosses a stage boundary combinationally.

## Test plan
- Add with carry wrap, WIDTH=32: a=0xFFFF_FFFF, b=0x0000_0001, cin=0, sub=0 -> 2 cycles later sum=0x0000_0000, cout=1, zero=1, ovf=0, p=0, g=1.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, add -> sum=0x8000_0000, ovf=1, cout=0. Also a=0x8000_0000, b=0x8000_0000 -> sum=0, cout=1, ovf=1, zero=1.
- Subtract: a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0. Also a=7, b=5 -> sum=2, cout=1. Also a=5, b=5 -> zero=1, cout=1.
- Cross-chunk carry and propagate: a=0x0000_FFFF, b=0x0000_0001 -> sum=0x0001_0000. Also a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, p=1, g=0.
- Back-pressure: stream 6 random operations with in_valid held high, and drop out_ready for 3 cycles mid-stream. Required response:
  - in_ready goes low during the stall.
  - Outputs hold during the stall.
  - All 6 results arrive in order, matching a reference model.
  - No extra or duplicated out_valid pulses.
- Reset mid-flight: accept 2 operations, then assert rst_n=0 before either completes. Required response:
  - Outputs and out_valid go to 0 immediately.
  - After release, out_valid stays 0 until a new operation is accepted.
  - The first result after release matches only the new operation.
  - Repeat the regression with WIDTH=16 and WIDTH=64.
